// File: rtl/prf_pkg.sv
// Shared physical-register-file definitions.
// Used by the free list, the rename map and the PRF itself.
//   PREG_W   : tag width (log2 of NUM_PREG)
//   NUM_PREG : number of physical registers (power of two)
//   NUM_ARCH : architectural registers, mapped 1:1 onto P0..P(NUM_ARCH-1) at reset
//   preg_t   : physical register tag
//   pptr_t   : free-list pointer; the extra MSB is the wrap bit
package prf_pkg;

  localparam int unsigned PREG_W   = 5;
  localparam int unsigned NUM_PREG = 32;
  localparam int unsigned NUM_ARCH = 8;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PREG_W:0]   pptr_t;

endpackage

// File: rtl/prf_free_list.sv
// Free-tag allocator for the physical register file.
// A circular queue of free tags with a speculative head (rename side), a committed head
// (retire side) and a tail (release side). Flush rolls the speculative head back to the
// committed head so tags handed to squashed instructions rejoin the pool.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   alloc_req        : rename consumes the head tag this cycle
//   alloc_ok         : a free tag is available (queue not empty)
//   alloc_tag        : tag at the speculative head, combinational
//   commit_valid     : one instruction retires this cycle
//   commit_has_dest  : the retiring instruction allocated a tag
//   commit_old_tag   : stale mapping to release (P0 is never released)
//   flush            : squash all uncommitted instructions
//   free_count       : tail - speculative head
//   err_overflow     : sticky, set when a release arrives while the queue is full
module prf_free_list
  import prf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_ok,
  output logic [PREG_W-1:0] alloc_tag,
  input  logic              commit_valid,
  input  logic              commit_has_dest,
  input  logic [PREG_W-1:0] commit_old_tag,
  input  logic              flush,
  output logic [PREG_W:0]   free_count,
  output logic              err_overflow
);

  localparam pptr_t FullDist  = pptr_t'(NUM_PREG);
  localparam pptr_t ResetTail = pptr_t'(NUM_PREG - NUM_ARCH);

  preg_t queue_q [NUM_PREG];
  pptr_t head_q, head_d;
  pptr_t cmt_head_q, cmt_head_d;
  pptr_t tail_q, tail_d;
  logic  err_q, err_d;

  logic empty, full;
  logic commit_adv, push_req, push;

  assign empty = (head_q == tail_q);
  // tail - cmt_head counts free plus in-flight tags; it reaches NUM_PREG only on misuse
  assign full  = ((tail_q - cmt_head_q) == FullDist);

  assign commit_adv = commit_valid & commit_has_dest;
  assign push_req   = commit_adv & (commit_old_tag != '0);
  assign push       = push_req & ~full;

  always_comb begin
    cmt_head_d = cmt_head_q;
    head_d     = head_q;
    tail_d     = tail_q;
    err_d      = err_q | (push_req & full);

    if (commit_adv) cmt_head_d = cmt_head_q + pptr_t'(1);
    if (push)       tail_d     = tail_q + pptr_t'(1);

    // Flush wins over allocation and includes a same-cycle commit
    if (flush) begin
      head_d = cmt_head_d;
    end else if (alloc_req && !empty) begin
      head_d = head_q + pptr_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      cmt_head_q <= '0;
      tail_q     <= ResetTail;
      err_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      cmt_head_q <= cmt_head_d;
      tail_q     <= tail_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PREG; i++) begin
        queue_q[i] <= (i < NUM_PREG - NUM_ARCH) ? preg_t'(NUM_ARCH + i) : '0;
      end
    end else if (push) begin
      queue_q[tail_q[PREG_W-1:0]] <= commit_old_tag;
    end
  end

  // Registered state only: a release this cycle never bypasses to alloc
  assign alloc_ok     = ~empty;
  assign alloc_tag    = queue_q[head_q[PREG_W-1:0]];
  assign free_count   = tail_q - head_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_prf_free_list.sv
module tb_prf_free_list;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic       alloc_ok;
  logic [4:0] alloc_tag;
  logic       commit_valid;
  logic       commit_has_dest;
  logic [4:0] commit_old_tag;
  logic       flush;
  logic [5:0] free_count;
  logic       err_overflow;

  int errors = 0;
  int checks = 0;

  prf_free_list dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_req       (alloc_req),
    .alloc_ok        (alloc_ok),
    .alloc_tag       (alloc_tag),
    .commit_valid    (commit_valid),
    .commit_has_dest (commit_has_dest),
    .commit_old_tag  (commit_old_tag),
    .flush           (flush),
    .free_count      (free_count),
    .err_overflow    (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample #1 after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req       = 1'b0;
    commit_valid    = 1'b0;
    commit_has_dest = 1'b0;
    commit_old_tag  = 5'd0;
    flush           = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc_one(input string tag, input int exp_tag);
    check({tag, "_ok"}, 32'(alloc_ok), 32'd1);
    check({tag, "_tag"}, 32'(alloc_tag), 32'(exp_tag));
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
  endtask

  task automatic commit(input logic [4:0] old_tag, input logic has_dest);
    commit_valid    = 1'b1;
    commit_has_dest = has_dest;
    commit_old_tag  = old_tag;
    tick();
    idle();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_fc"}, 32'(free_count), 32'd24);
    check({tag, "_tag"}, 32'(alloc_tag), 32'd8);
    check({tag, "_ok"}, 32'(alloc_ok), 32'd1);
    check({tag, "_err"}, 32'(err_overflow), 32'd0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    check_reset_state("rst_init");
    rst = 1'b0;

    // Five allocations, then reset mid-run
    for (int i = 0; i < 5; i++) alloc_one("pre5", 8 + i);
    check("pre5_fc", 32'(free_count), 32'd19);
    do_reset();
    check_reset_state("rst_mid");

    // Drain all 24 free tags in order
    for (int i = 0; i < 24; i++) alloc_one("drain", 8 + i);
    check("drain_ok", 32'(alloc_ok), 32'd0);
    check("drain_fc", 32'(free_count), 32'd0);

    // Commit with old tag 0: nothing pushed; alloc while empty ignored
    alloc_req = 1'b1;
    commit_valid = 1'b1;
    commit_has_dest = 1'b1;
    commit_old_tag = 5'd0;
    tick();
    idle();
    check("p0_fc", 32'(free_count), 32'd0);
    check("p0_ok", 32'(alloc_ok), 32'd0);

    // Release tag 3 alongside an alloc_req: no same-cycle bypass
    alloc_req = 1'b1;
    commit_valid = 1'b1;
    commit_has_dest = 1'b1;
    commit_old_tag = 5'd3;
    #1;
    check("nobypass_ok", 32'(alloc_ok), 32'd0);
    tick();
    idle();
    check("rel3_ok", 32'(alloc_ok), 32'd1);
    check("rel3_tag", 32'(alloc_tag), 32'd3);
    check("rel3_fc", 32'(free_count), 32'd1);

    // Flush: head back to cmt_head = 2 (tail 25)
    flush = 1'b1;
    tick();
    idle();
    check("fl_a_fc", 32'(free_count), 32'd23);
    check("fl_a_tag", 32'(alloc_tag), 32'd10);

    // Alloc 6, commit 2, flush
    do_reset();
    for (int i = 0; i < 6; i++) alloc_one("a6", 8 + i);
    commit(5'd1, 1'b1);
    commit(5'd2, 1'b1);
    check("c2_fc", 32'(free_count), 32'd20);
    flush = 1'b1;
    tick();
    idle();
    check("fl_b_fc", 32'(free_count), 32'd24);
    for (int i = 0; i < 22; i++) alloc_one("fl_b_seq", 10 + i);
    alloc_one("fl_b_r1", 1);
    alloc_one("fl_b_r2", 2);
    check("fl_b_empty", 32'(alloc_ok), 32'd0);

    // commit_valid without a destination changes nothing
    do_reset();
    commit(5'd6, 1'b0);
    check("nodest_fc", 32'(free_count), 32'd24);
    check("nodest_tag", 32'(alloc_tag), 32'd8);

    // Same cycle flush + alloc + release of tag 5
    do_reset();
    for (int i = 0; i < 3; i++) alloc_one("a3", 8 + i);
    commit(5'd1, 1'b1);
    flush = 1'b1;
    alloc_req = 1'b1;
    commit_valid = 1'b1;
    commit_has_dest = 1'b1;
    commit_old_tag = 5'd5;
    tick();
    idle();
    check("mix_fc", 32'(free_count), 32'd24);
    check("mix_tag", 32'(alloc_tag), 32'd10);
    for (int i = 0; i < 22; i++) alloc_one("mix_seq", 10 + i);
    alloc_one("mix_r1", 1);
    alloc_one("mix_r5", 5);
    check("mix_empty", 32'(alloc_ok), 32'd0);

    // Overflow: 56 dest-only commits make tail - cmt_head wrap to 32
    do_reset();
    for (int i = 0; i < 56; i++) commit(5'd0, 1'b1);
    check("ovf_pre_err", 32'(err_overflow), 32'd0);
    check("ovf_pre_fc", 32'(free_count), 32'd24);
    commit(5'd7, 1'b1);
    check("ovf_err", 32'(err_overflow), 32'd1);
    check("ovf_fc", 32'(free_count), 32'd24);
    check("ovf_tag", 32'(alloc_tag), 32'd8);
    // No longer full: this release is accepted, error stays sticky
    commit(5'd9, 1'b1);
    check("ovf_sticky", 32'(err_overflow), 32'd1);
    check("ovf_push_fc", 32'(free_count), 32'd25);
    tick();
    check("ovf_hold", 32'(err_overflow), 32'd1);
    do_reset();
    check_reset_state("rst_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
